// File: rtl/iru_pkg.sv
// Shared constants, types and the sine table for the image rotation unit.
package iru_pkg;

  localparam int IMG_DIM    = 20;
  localparam int Q_ROWS     = 5;
  localparam int Q_COLS     = 80;
  localparam int NUM_ANGLES = 36;
  localparam int TRIG_FRAC  = 14;
  localparam int NUM_PIX    = IMG_DIM * IMG_DIM;

  localparam logic [8:0] LAST_PIX = 9'(NUM_PIX - 1);

  // Half-pixel-scaled window centre in Q.14: adds 20*2^14 before the /2^15 floor.
  localparam int CENTRE_OFS = IMG_DIM << TRIG_FRAC;

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    DONE
  } state_t;

  typedef logic [7:0] pixel_t;

  // round(sin(k*10 deg) * 2^14); quadrant points are exact.
  localparam logic signed [15:0] SIN_TAB [NUM_ANGLES] = '{
     16'sd0,      16'sd2845,   16'sd5604,   16'sd8192,   16'sd10531,  16'sd12551,
     16'sd14189,  16'sd15396,  16'sd16135,  16'sd16384,  16'sd16135,  16'sd15396,
     16'sd14189,  16'sd12551,  16'sd10531,  16'sd8192,   16'sd5604,   16'sd2845,
     16'sd0,     -16'sd2845,  -16'sd5604,  -16'sd8192,  -16'sd10531, -16'sd12551,
    -16'sd14189, -16'sd15396, -16'sd16135, -16'sd16384, -16'sd16135, -16'sd15396,
    -16'sd14189, -16'sd12551, -16'sd10531, -16'sd8192,  -16'sd5604,  -16'sd2845
  };

  // cos(k) = sin(k + 90 deg), i.e. table index (k + 9) mod 36.
  function automatic logic [5:0] cos_index(input logic [5:0] k);
    return (k >= 6'd27) ? (k - 6'd27) : (k + 6'd9);
  endfunction

endpackage

// File: rtl/iru_trig_lut.sv
// Combinational sin/cos lookup for the 36 rotation angles (Q1.14).
module iru_trig_lut
  import iru_pkg::*;
(
  input  logic        [5:0]  k,
  output logic signed [15:0] sin_q,
  output logic signed [15:0] cos_q
);

  // Both values come from the one sine table; cosine is a 90 degree index shift.
  always_comb begin
    sin_q = SIN_TAB[k];
    cos_q = SIN_TAB[cos_index(k)];
  end

endmodule

// File: rtl/iru.sv
// Image rotation unit: nearest-neighbour inverse-mapped rotation of a 20x20
// byte window about its centre, one output pixel per clock.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a start; in_ready high
//   ROTATE | window captured, producing output pixel cnt each cycle
//   DONE   | result valid on q; held until the consumer accepts it
//
// rst_n is active-high and synchronous despite its name.
module iru
  import iru_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rnn_out_ready,
  input  logic                bcau_in_ready,
  input  logic [35:0]         rnn_out,
  input  logic [7:0]          d [Q_ROWS-1:0][Q_COLS-1:0],
  output logic                in_ready,
  output logic                out_ready,
  output logic [7:0]          q [Q_ROWS-1:0][Q_COLS-1:0]
);

  localparam logic signed [6:0] MID2 = 7'(IMG_DIM - 1);

  state_t state, state_nxt;
  logic   capture;

  logic [8:0] cnt;
  logic [5:0] ang_k;
  logic [5:0] ang_dec;

  pixel_t d_flat  [NUM_PIX];
  pixel_t pix_buf [NUM_PIX];
  pixel_t q_mem   [NUM_PIX];

  logic [4:0]         img_r, img_c;
  logic signed [6:0]  u, v;
  logic signed [15:0] sin_q, cos_q;
  logic signed [31:0] u_w, v_w, sin_w, cos_w;
  logic signed [31:0] x_acc, y_acc;
  logic signed [31:0] src_r_s, src_c_s;
  logic               src_valid;
  logic [8:0]         src_idx;

  // The port arrays are row-of-80 slices of a linear 400-pixel image.
  for (genvar gr = 0; gr < Q_ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < Q_COLS; gc++) begin : g_col
      assign d_flat[gr*Q_COLS + gc] = d[gr][gc];
      assign q[gr][gc]              = q_mem[gr*Q_COLS + gc];
    end
  end

  // Lowest set bit of the one-hot class wins; no bit set means 0 degrees.
  always_comb begin
    ang_dec = '0;
    for (int i = NUM_ANGLES - 1; i >= 0; i--) begin
      if (rnn_out[i]) ang_dec = 6'(i);
    end
  end

  iru_trig_lut u_trig (
    .k     (ang_k),
    .sin_q (sin_q),
    .cos_q (cos_q)
  );

  // Inverse map the current output pixel back into the captured window.
  always_comb begin
    img_r   = 5'(cnt / 9'(IMG_DIM));
    img_c   = 5'(cnt % 9'(IMG_DIM));
    u       = $signed({1'b0, img_c, 1'b0}) - MID2;
    v       = $signed({1'b0, img_r, 1'b0}) - MID2;
    u_w     = 32'(u);
    v_w     = 32'(v);
    sin_w   = 32'(sin_q);
    cos_w   = 32'(cos_q);
    x_acc   = cos_w * u_w + sin_w * v_w;
    y_acc   = cos_w * v_w - sin_w * u_w;
    src_c_s = (x_acc + CENTRE_OFS) >>> (TRIG_FRAC + 1);
    src_r_s = (y_acc + CENTRE_OFS) >>> (TRIG_FRAC + 1);
    src_valid = (src_c_s >= 0) && (src_c_s < IMG_DIM) &&
                (src_r_s >= 0) && (src_r_s < IMG_DIM);
    src_idx = 9'(src_r_s[4:0]) * 9'(IMG_DIM) + 9'(src_c_s[4:0]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_ready = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (rnn_out_ready) begin
          capture   = 1'b1;
          state_nxt = ROTATE;
        end
      end
      ROTATE: begin
        if (cnt == LAST_PIX) state_nxt = DONE;
      end
      DONE: begin
        out_ready = 1'b1;
        if (bcau_in_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture on start, then write one rotated pixel per cycle; the counter stops at the last pixel.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt   <= '0;
      ang_k <= '0;
      q_mem <= '{default: 8'h00};
    end else if (capture) begin
      cnt     <= '0;
      ang_k   <= ang_dec;
      pix_buf <= d_flat;
    end else if (state == ROTATE) begin
      q_mem[cnt] <= src_valid ? pix_buf[src_idx] : 8'h00;
      if (cnt != LAST_PIX) cnt <= cnt + 9'd1;
    end
  end

endmodule

// File: tb/tb_iru.sv
// Directed bench for the image rotation unit.
module tb_iru;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rnn_out_ready;
  logic        bcau_in_ready;
  logic [35:0] rnn_out;
  logic [7:0]  d [4:0][79:0];
  logic        in_ready;
  logic        out_ready;
  logic [7:0]  q [4:0][79:0];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iru dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rnn_out_ready (rnn_out_ready),
    .bcau_in_ready (bcau_in_ready),
    .rnn_out       (rnn_out),
    .d             (d),
    .in_ready      (in_ready),
    .out_ready     (out_ready),
    .q             (q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] qpix(input int p);
    return q[p / 80][p % 80];
  endfunction

  // mode 0: byte = pixel index mod 256; 1: all 8'hFF; 2: junk
  task automatic fill_d(input int mode);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 80; c++)
        d[r][c] = (mode == 0) ? 8'((r * 80 + c) % 256) : (mode == 1) ? 8'hFF : 8'hA5;
  endtask

  // Start at edge N; returns half a cycle after edge N with inputs scrambled.
  task automatic start_run(input logic [35:0] ang, input int mode);
    @(negedge clk);
    fill_d(mode);
    rnn_out       = ang;
    rnn_out_ready = 1'b1;
    @(negedge clk);
    rnn_out_ready = 1'b0;
    rnn_out       = 36'hA_5A5A_5A5A;
    fill_d(2);
  endtask

  // cyc counts edges after the start edge; pulses both strobes before edge pulse_at+1.
  task automatic wait_done(input int pulse_at, output int cyc, output bit in_ready_seen);
    cyc = 0;
    in_ready_seen = 1'b0;
    while (cyc < 1000) begin
      if (cyc == pulse_at) begin
        rnn_out_ready = 1'b1;
        bcau_in_ready = 1'b1;
        rnn_out       = 36'h1;
      end else begin
        rnn_out_ready = 1'b0;
        bcau_in_ready = 1'b0;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (in_ready) in_ready_seen = 1'b1;
      if (out_ready) break;
    end
    rnn_out_ready = 1'b0;
    bcau_in_ready = 1'b0;
  endtask

  // mode 0: identity; 1: 180 deg; 2: 90 deg; 3: all zero
  task automatic count_bad(input int mode, output int bad, output int first);
    logic [7:0] exp;
    bad   = 0;
    first = -1;
    for (int p = 0; p < 400; p++) begin
      case (mode)
        0:       exp = 8'(p % 256);
        1:       exp = 8'((399 - p) % 256);
        2:       exp = 8'(((19 - p % 20) * 20 + p / 20) % 256);
        default: exp = 8'h00;
      endcase
      if (qpix(p) !== exp) begin
        bad++;
        if (first < 0) first = p;
      end
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    bcau_in_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_rel_out_ready"}, 32'(out_ready), 32'd0);
    check({tag, "_rel_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    bcau_in_ready = 1'b0;
  endtask

  initial begin
    int  cyc;
    bit  seen;
    int  bad;
    int  first;

    rnn_out_ready = 1'b0;
    bcau_in_ready = 1'b0;
    rnn_out       = '0;
    fill_d(0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_ready", 32'(out_ready), 32'd0);
    count_bad(3, bad, first);
    check("reset_q_zero", 32'(bad), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;

    // 0 degrees: exact latency, in_ready low, identity despite d changing after capture
    start_run(36'h1, 0);
    wait_done(-1, cyc, seen);
    check("lat_0deg", 32'(cyc), 32'd400);
    check("in_ready_low_0deg", 32'(seen), 32'd0);
    count_bad(0, bad, first);
    check("identity_0deg", 32'(bad), 32'd0);
    check("q_4_79_0deg", 32'(q[4][79]), 32'h8F);

    // out_ready holds while not accepted
    repeat (50) @(posedge clk);
    #1;
    check("hold50_out_ready", 32'(out_ready), 32'd1);
    check("hold50_in_ready", 32'(in_ready), 32'd0);

    // Start strobe coincident with release must be ignored
    @(negedge clk);
    bcau_in_ready = 1'b1;
    rnn_out_ready = 1'b1;
    rnn_out       = 36'h1 << 18;
    @(posedge clk);
    #1;
    check("release_out_ready", 32'(out_ready), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    bcau_in_ready = 1'b0;
    rnn_out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("no_start_on_release", 32'(in_ready), 32'd1);
    check("q_kept_after_release", 32'(q[4][79]), 32'h8F);

    // 180 degrees with a start/accept pulse mid-run
    start_run(36'h1 << 18, 0);
    wait_done(100, cyc, seen);
    check("lat_180deg", 32'(cyc), 32'd400);
    count_bad(1, bad, first);
    check("map_180deg", 32'(bad), 32'd0);
    check("q_0_0_180deg", 32'(q[0][0]), 32'h8F);
    release_result("r180");

    // 90 degrees; accept pulse on the last ROTATE cycle is ignored
    start_run(36'h1 << 9, 0);
    wait_done(399, cyc, seen);
    check("lat_90deg", 32'(cyc), 32'd400);
    @(posedge clk);
    #1;
    check("out_ready_after_late_bcau", 32'(out_ready), 32'd1);
    count_bad(2, bad, first);
    check("map_90deg", 32'(bad), 32'd0);
    check("q_0_0_90deg", 32'(q[0][0]), 32'h7C);
    release_result("r90");

    // 40 degrees, all 8'hFF: corners fall outside, centre inside
    start_run(36'h1 << 4, 1);
    wait_done(-1, cyc, seen);
    check("q_0_0_40deg", 32'(q[0][0]), 32'h00);
    check("q_4_79_40deg", 32'(q[4][79]), 32'h00);
    check("q_centre_40deg", 32'(q[2][29]), 32'hFF);
    release_result("r40");

    // No bit set: identity
    start_run(36'h0, 0);
    wait_done(-1, cyc, seen);
    check("lat_zero_class", 32'(cyc), 32'd400);
    count_bad(0, bad, first);
    check("identity_zero_class", 32'(bad), 32'd0);
    release_result("rzero");

    // Bits 3 and 7: 30 degrees
    start_run((36'h1 << 3) | (36'h1 << 7), 0);
    wait_done(-1, cyc, seen);
    check("q_p10_30deg", 32'(q[0][10]), 32'd25);
    check("q_p200_30deg", 32'(q[2][40]), 32'd46);
    check("q_0_0_30deg", 32'(q[0][0]), 32'h00);
    release_result("r30");

    // Reset mid-ROTATE
    start_run(36'h1 << 18, 0);
    repeat (150) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_out_ready", 32'(out_ready), 32'd0);
    count_bad(3, bad, first);
    check("midreset_q_zero", 32'(bad), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
